// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch front end.
//   Instruction field bit positions used when splitting the IF/ID word for decode,
//   datapath widths, the default reset PC and the PC increment helper.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  // Instruction layout: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
  // The 8-bit immediate overlays rs1/rs2.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Word-addressed PC: plain binary increment, wrapping FFFF -> 0000.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding slot for an instruction and its PC.
//   Catches a memory response that arrives while decode is stalled, so the
//   response is not lost and no re-fetch is needed.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push                store push_instr/push_pc (slot becomes full)
//   pop                 slot contents consumed (slot becomes empty)
//   flush               empty the slot; wins over push and pop
//   push_instr, push_pc data written on push
//   valid, instr, pc    slot state and contents
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [PC_W-1:0]    push_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);

  // Push and pop never coincide in practice (push needs IF/ID blocked, pop
  // needs it free), so push is simply given precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      instr <= push_instr;
      pc    <= push_pc;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch stage feeding decode.
//   Holds the PC, issues word-addressed requests to instruction memory (at most
//   one outstanding), captures responses into the IF/ID register and splits out
//   the decode fields. Honours stall from hazard logic and redirect from branch
//   resolution.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   stall                         decode cannot accept; hold IF/ID
//   branch_taken, branch_target   redirect pulse and new PC
//   imem_req, imem_addr           request valid and word address (= pc)
//   imem_gnt                      memory accepts the request this cycle
//   imem_rvalid, imem_rdata       response valid and instruction word
//   if_id_valid/instr/pc          IF/ID pipeline register
//   if_id_opcode/rd_addr/rs1_addr/rs2_addr/imm_off  field slices of if_id_instr
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              INSTR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [3:0]         if_id_opcode,
  output logic [3:0]         if_id_rd_addr,
  output logic [3:0]         if_id_rs1_addr,
  output logic [3:0]         if_id_rs2_addr,
  output logic [7:0]         if_id_imm_off
);

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    req_pc;
  logic               outstanding;
  logic               discard;

  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  logic               can_load;
  logic               resp_live;
  logic               grant;
  logic               skid_push;
  logic               skid_pop;

  assign can_load  = !stall || !if_id_valid;
  assign resp_live = imem_rvalid && !discard;

  // A new request is allowed when the slot is free (or freeing this cycle),
  // the skid slot is empty and an arriving response will not need the skid
  // slot. Gating with rst keeps the request low while reset is held.
  assign imem_req = !rst && !branch_taken && !skid_valid
                    && (!outstanding || imem_rvalid)
                    && !(resp_live && stall && if_id_valid);
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  assign skid_push = !branch_taken && resp_live && !can_load;
  assign skid_pop  = !branch_taken && skid_valid && can_load;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (skid_push),
    .pop        (skid_pop),
    .flush      (branch_taken),
    .push_instr (imem_rdata),
    .push_pc    (req_pc),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // PC and request tracking. On redirect, a request still in flight cannot be
  // cancelled at the memory, so its response is marked for discard instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else if (branch_taken) begin
      pc <= branch_target;
      if (imem_rvalid) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end else if (outstanding) begin
        discard <= 1'b1;
      end
    end else begin
      if (grant) begin
        pc          <= pc_next(pc);
        req_pc      <= pc;
        outstanding <= 1'b1;
      end else if (imem_rvalid) begin
        outstanding <= 1'b0;
      end
      if (imem_rvalid && discard) begin
        discard <= 1'b0;
      end
    end
  end

  // IF/ID register. The skid slot is older than anything in flight, so it is
  // drained first; while it is full no request is issued, so no response can
  // compete with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_instr <= '0;
      if_id_pc    <= '0;
    end else if (branch_taken) begin
      if_id_valid <= 1'b0;
    end else if (skid_pop) begin
      if_id_valid <= 1'b1;
      if_id_instr <= skid_instr;
      if_id_pc    <= skid_pc;
    end else if (resp_live && can_load) begin
      if_id_valid <= 1'b1;
      if_id_instr <= imem_rdata;
      if_id_pc    <= req_pc;
    end else if (!stall) begin
      if_id_valid <= 1'b0;
    end
  end

  assign if_id_opcode   = if_id_instr[OPC_MSB:OPC_LSB];
  assign if_id_rd_addr  = if_id_instr[RD_MSB:RD_LSB];
  assign if_id_rs1_addr = if_id_instr[RS1_MSB:RS1_LSB];
  assign if_id_rs2_addr = if_id_instr[RS2_MSB:RS2_LSB];
  assign if_id_imm_off  = if_id_instr[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: self-checking bench for inst_fetch_unit.
//   Main instance (RESET_PC=0) exercises streaming, wait states, stall into the
//   skid slot, redirect with a late response, redirect+stall with a full slot
//   and reset mid-request. A second instance (RESET_PC=FFFE) checks PC wrap.
//   Expected IF/ID contents are queued at grant time and popped when IF/ID loads.
module tb_inst_fetch_unit;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } expEntry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branchTaken;
  logic [15:0] branchTarget;
  logic        imemReq, imemGnt, imemRvalid;
  logic [15:0] imemAddr, imemRdata;
  logic        ifIdValid;
  logic [15:0] ifIdInstr, ifIdPc;
  logic [3:0]  ifIdOpcode, ifIdRd, ifIdRs1, ifIdRs2;
  logic [7:0]  ifIdImm;

  logic        wStall, wBranch;
  logic [15:0] wTarget;
  logic        wReq, wGnt, wRvalid;
  logic [15:0] wAddr, wRdata;
  logic        wValid;
  logic [15:0] wInstr, wPc;
  logic [3:0]  wOpcode, wRd, wRs1, wRs2;
  logic [7:0]  wImm;

  int          vectors = 0;
  int          miscompares = 0;

  expEntry_t   sbQueue[$];
  expEntry_t   wQueue[$];
  expEntry_t   lastEntry;
  logic [15:0] expPc;
  logic [15:0] wExpPc;
  bit          holdNext;
  bit          pendValid;
  logic [15:0] pendAddr;
  int          pendCnt;
  bit          wPend;
  logic [15:0] wPendAddr;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(16'h0000), .INSTR_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branchTaken),
    .branch_target  (branchTarget),
    .imem_req       (imemReq),
    .imem_addr      (imemAddr),
    .imem_gnt       (imemGnt),
    .imem_rvalid    (imemRvalid),
    .imem_rdata     (imemRdata),
    .if_id_valid    (ifIdValid),
    .if_id_instr    (ifIdInstr),
    .if_id_pc       (ifIdPc),
    .if_id_opcode   (ifIdOpcode),
    .if_id_rd_addr  (ifIdRd),
    .if_id_rs1_addr (ifIdRs1),
    .if_id_rs2_addr (ifIdRs2),
    .if_id_imm_off  (ifIdImm)
  );

  inst_fetch_unit #(.RESET_PC(16'hFFFE), .INSTR_W(16)) dutWrap (
    .clk            (clk),
    .rst            (rst),
    .stall          (wStall),
    .branch_taken   (wBranch),
    .branch_target  (wTarget),
    .imem_req       (wReq),
    .imem_addr      (wAddr),
    .imem_gnt       (wGnt),
    .imem_rvalid    (wRvalid),
    .imem_rdata     (wRdata),
    .if_id_valid    (wValid),
    .if_id_instr    (wInstr),
    .if_id_pc       (wPc),
    .if_id_opcode   (wOpcode),
    .if_id_rd_addr  (wRd),
    .if_id_rs1_addr (wRs1),
    .if_id_rs2_addr (wRs2),
    .if_id_imm_off  (wImm)
  );

  // Instruction memory contents
  function automatic logic [15:0] memData(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0009) return 16'hABCD;
    return {a[7:0] ^ 8'hC3, a[7:0] ^ 8'h5A};
  endfunction

  task automatic checkVal(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkEntry(input string tag, input expEntry_t e, input logic [15:0] instrObs,
                            input logic [15:0] pcObs, input logic [3:0] opc, input logic [3:0] rd,
                            input logic [3:0] rs1, input logic [3:0] rs2, input logic [7:0] imm);
    logic [15:0] ei;
    ei = e.instr;
    checkVal({tag, "_instr"}, instrObs, ei);
    checkVal({tag, "_pc"}, pcObs, e.pc);
    checkVal({tag, "_opcode"}, {12'b0, opc}, {12'b0, ei[15:12]});
    checkVal({tag, "_rd"}, {12'b0, rd}, {12'b0, ei[11:8]});
    checkVal({tag, "_rs1"}, {12'b0, rs1}, {12'b0, ei[7:4]});
    checkVal({tag, "_rs2"}, {12'b0, rs2}, {12'b0, ei[3:0]});
    checkVal({tag, "_imm"}, {8'b0, imm}, {8'b0, ei[7:0]});
  endtask

  task automatic checkOutput(input logic g, input logic s, input logic b, input logic [15:0] tgt,
                             input int dly, input int reqE, input int valE);
    expEntry_t cur;
    if (valE >= 0) checkVal("if_id_valid", {15'b0, ifIdValid}, 16'(valE));
    if (ifIdValid === 1'b1) begin
      if (holdNext) begin
        checkEntry("hold", lastEntry, ifIdInstr, ifIdPc, ifIdOpcode, ifIdRd, ifIdRs1, ifIdRs2, ifIdImm);
      end else begin
        checkVal("sb_expected_entry", {15'b0, sbQueue.size() != 0}, 16'd1);
        if (sbQueue.size() != 0) begin
          cur = sbQueue.pop_front();
          lastEntry = cur;
          checkEntry("load", cur, ifIdInstr, ifIdPc, ifIdOpcode, ifIdRd, ifIdRs1, ifIdRs2, ifIdImm);
        end
      end
    end
    holdNext = s && (ifIdValid === 1'b1) && !b;

    if (reqE >= 0) checkVal("imem_req", {15'b0, imemReq}, 16'(reqE));
    if (imemReq === 1'b1) begin
      checkVal("imem_addr", imemAddr, expPc);
      if (g) begin
        sbQueue.push_back({memData(expPc), expPc});
        pendValid = 1'b1;
        pendAddr  = expPc;
        pendCnt   = dly;
        expPc     = expPc + 16'd1;
      end
    end
    if (b) begin
      sbQueue.delete();
      expPc = tgt;
    end

    if (wValid === 1'b1) begin
      checkVal("wrap_expected_entry", {15'b0, wQueue.size() != 0}, 16'd1);
      if (wQueue.size() != 0) begin
        cur = wQueue.pop_front();
        checkEntry("wrap", cur, wInstr, wPc, wOpcode, wRd, wRs1, wRs2, wImm);
      end
    end
    if (wGnt) begin
      checkVal("wrap_req", {15'b0, wReq}, 16'd1);
      checkVal("wrap_addr", wAddr, wExpPc);
      if (wReq === 1'b1) begin
        wQueue.push_back({memData(wExpPc), wExpPc});
        wPend     = 1'b1;
        wPendAddr = wExpPc;
        wExpPc    = wExpPc + 16'd1;
      end
    end
  endtask

  // One clock cycle: drive inputs and memory responses, check, advance.
  // reqE/valE of -1 mean "not checked this cycle".
  task automatic applyStimulus(input logic g, input logic s, input logic b, input logic [15:0] tgt,
                               input int dly, input int reqE, input int valE);
    imemGnt      = g;
    stall        = s;
    branchTaken  = b;
    branchTarget = tgt;
    imemRvalid   = 1'b0;
    imemRdata    = 16'hFFFF;
    if (pendValid) begin
      if (pendCnt == 0) begin
        imemRvalid = 1'b1;
        imemRdata  = memData(pendAddr);
        pendValid  = 1'b0;
      end else begin
        pendCnt--;
      end
    end
    wRvalid = wPend;
    wRdata  = wPend ? memData(wPendAddr) : 16'hFFFF;
    wPend   = 1'b0;
    #1;
    checkOutput(g, s, b, tgt, dly, reqE, valE);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic resetPulse();
    rst         = 1'b1;
    imemGnt     = 1'b0;
    imemRvalid  = 1'b0;
    stall       = 1'b0;
    branchTaken = 1'b0;
    wGnt        = 1'b0;
    wRvalid     = 1'b0;
    #1;
    checkVal("rst_imem_req", {15'b0, imemReq}, 16'd0);
    checkVal("rst_imem_addr", imemAddr, 16'h0000);
    checkVal("rst_if_id_valid", {15'b0, ifIdValid}, 16'd0);
    checkVal("rst_if_id_instr", ifIdInstr, 16'h0000);
    checkVal("rst_if_id_pc", ifIdPc, 16'h0000);
    checkVal("rst_fields", {ifIdOpcode, ifIdRd, ifIdRs1, ifIdRs2}, 16'h0000);
    checkVal("rst_imm", {8'b0, ifIdImm}, 16'h0000);
    checkVal("rst_wrap_req", {15'b0, wReq}, 16'd0);
    checkVal("rst_wrap_addr", wAddr, 16'hFFFE);
    sbQueue.delete();
    wQueue.delete();
    pendValid = 1'b0;
    wPend     = 1'b0;
    holdNext  = 1'b0;
    expPc     = 16'h0000;
    wExpPc    = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = 16'h0000;
    imemGnt = 1'b0; imemRvalid = 1'b0; imemRdata = 16'h0000;
    wStall = 1'b0; wBranch = 1'b0; wTarget = 16'h0000;
    wGnt = 1'b0; wRvalid = 1'b0; wRdata = 16'h0000;
    pendValid = 1'b0; pendAddr = 16'h0; pendCnt = 0;
    wPend = 1'b0; wPendAddr = 16'h0; holdNext = 1'b0; lastEntry = '0;
    expPc = 16'h0000; wExpPc = 16'hFFFE;
    #2;
    $display("[TB] reset and streaming fetch");
    resetPulse();
    wGnt = 1'b1;
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1);
    wGnt = 1'b0;
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1);

    $display("[TB] wait states at address 5");
    applyStimulus(0, 0, 0, 16'h0, 0, 1, 1);
    applyStimulus(0, 0, 0, 16'h0, 0, 1, 1);
    applyStimulus(0, 0, 0, 16'h0, 0, 1, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1);

    $display("[TB] stall with response in flight");
    applyStimulus(1, 1, 0, 16'h0, 0, 0, 1);
    applyStimulus(1, 1, 0, 16'h0, 0, 0, 1);
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 1);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1);
    applyStimulus(1, 0, 0, 16'h0, 2, 1, 0);

    $display("[TB] redirect with outstanding request");
    applyStimulus(1, 0, 1, 16'h0040, 0, 0, 1);
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1);

    $display("[TB] redirect and stall with skid slot full");
    applyStimulus(1, 1, 0, 16'h0, 0, 0, 1);
    applyStimulus(1, 1, 1, 16'h0080, 0, 0, 1);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1);

    $display("[TB] reset during an outstanding request");
    resetPulse();
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1);
    applyStimulus(0, 0, 0, 16'h0, 0, -1, 1);

    for (int i = 0; i < 20 && sbQueue.size() != 0; i++) begin
      applyStimulus(0, 0, 0, 16'h0, 0, -1, -1);
    end
    checkVal("sb_drained", 16'(sbQueue.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
